// File: rtl/store_buffer_ctrl_pkg.sv
// Shared definitions for the committed-store buffer: default sizing,
// the WB-to-store-buffer bus width and the drain FSM state encoding.
package store_buffer_ctrl_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned SB_SW    = SB_DW / 8;

  // WB -> store buffer bus: {we, addr, wdata, wstrb}
  localparam int unsigned WB_SB_BUS_WD = 1 + SB_AW + SB_DW + SB_SW;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_buffer_ctrl_fifo.sv
// Store buffer storage: circular FIFO with registered count, per-entry
// valid bits and a word-granular address match vector for load hazards.
module sb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_wdata_i,
  input  logic [DW/8-1:0]        push_wstrb_i,
  input  logic                   pop_i,
  input  logic [AW-1:0]          cmp_addr_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [AW-1:0]          head_addr_o,
  output logic [DW-1:0]          head_wdata_o,
  output logic [DW/8-1:0]        head_wstrb_o,
  output logic [DEPTH-1:0]       match_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = DW / 8;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q  [DEPTH];
  logic [AW-1:0]    addr_d  [DEPTH];
  logic [DW-1:0]    wdata_q [DEPTH];
  logic [DW-1:0]    wdata_d [DEPTH];
  logic [SW-1:0]    wstrb_q [DEPTH];
  logic [SW-1:0]    wstrb_d [DEPTH];

  // Byte offset within the word never takes part in the hazard compare.
  logic cmp_lsb_unused;
  assign cmp_lsb_unused = ^cmp_addr_i[1:0];

  // Next-state for pointers, count, valid bits and entry payloads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    if (push_i) begin
      addr_d[wr_ptr_q]  = push_addr_i;
      wdata_d[wr_ptr_q] = push_wdata_i;
      wstrb_d[wr_ptr_q] = push_wstrb_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wstrb_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  // Per-entry same-word compare against the load address.
  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_q[i] && (addr_q[i][AW-1:2] == cmp_addr_i[AW-1:2]);
    end
  end

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_wdata_o = wdata_q[rd_ptr_q];
  assign head_wstrb_o = wstrb_q[rd_ptr_q];

endmodule

// File: rtl/store_buffer_ctrl.sv
// Committed-store buffer controller: accepts WB stores, drains them in
// order to the shared dcache port, yields to loads and flags load hazards.
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_we_i,
  input  logic [AW-1:0]          wb_addr_i,
  input  logic [DW-1:0]          wb_wdata_i,
  input  logic [DW/8-1:0]        wb_wstrb_i,
  output logic                   sb_full_o,
  output logic                   sb_empty_o,
  output logic [$clog2(DEPTH):0] sb_count_o,
  output logic                   sb_ovf_o,
  input  logic                   ld_busy_i,
  input  logic                   ld_check_i,
  input  logic [AW-1:0]          ld_addr_i,
  output logic                   ld_hazard_o,
  output logic                   dc_req_o,
  output logic [AW-1:0]          dc_addr_o,
  output logic [DW-1:0]          dc_wdata_o,
  output logic [DW/8-1:0]        dc_wstrb_o,
  input  logic                   dc_addr_ok_i,
  input  logic                   dc_data_ok_i
);

  sb_state_e        state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_wdata;
  logic [DW/8-1:0]  head_wstrb;
  logic [DEPTH-1:0] match;

  assign push = wb_we_i && !sb_full_o;
  assign pop  = (state_q == SB_WAIT) && dc_data_ok_i;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_addr_i  (wb_addr_i),
    .push_wdata_i (wb_wdata_i),
    .push_wstrb_i (wb_wstrb_i),
    .pop_i        (pop),
    .cmp_addr_i   (ld_addr_i),
    .full_o       (sb_full_o),
    .empty_o      (sb_empty_o),
    .count_o      (sb_count_o),
    .head_addr_o  (head_addr),
    .head_wdata_o (head_wdata),
    .head_wstrb_o (head_wstrb),
    .match_o      (match)
  );

  // Drain FSM next state and sticky overflow; loads win unless full.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q | (wb_we_i & sb_full_o);
    unique case (state_q)
      SB_IDLE: if (!sb_empty_o && (!ld_busy_i || sb_full_o)) state_d = SB_REQ;
      SB_REQ:  if (dc_addr_ok_i) state_d = SB_WAIT;
      SB_WAIT: if (dc_data_ok_i) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  // FSM state and overflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SB_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Request payload is the registered head, presented only while requesting.
  always_comb begin
    dc_req_o   = (state_q == SB_REQ);
    dc_addr_o  = '0;
    dc_wdata_o = '0;
    dc_wstrb_o = '0;
    if (dc_req_o) begin
      dc_addr_o  = head_addr;
      dc_wdata_o = head_wdata;
      dc_wstrb_o = head_wstrb;
    end
  end

  assign ld_hazard_o = ld_check_i && (|match);
  assign sb_ovf_o    = ovf_q;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_store_buffer_ctrl;
  import store_buffer_ctrl_pkg::*;

  localparam int DEPTH = SB_DEPTH;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_we = 1'b0;
  logic [31:0]   wb_addr = '0;
  logic [31:0]   wb_wdata = '0;
  logic [3:0]    wb_wstrb = '0;
  logic          sb_full, sb_empty, sb_ovf;
  logic [2:0]    sb_count;
  logic          ld_busy = 1'b0;
  logic          ld_check = 1'b0;
  logic [31:0]   ld_addr = '0;
  logic          ld_hazard;
  logic          dc_req;
  logic [31:0]   dc_addr, dc_wdata;
  logic [3:0]    dc_wstrb;
  logic          dc_addr_ok = 1'b0;
  logic          dc_data_ok = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_we_i      (wb_we),
    .wb_addr_i    (wb_addr),
    .wb_wdata_i   (wb_wdata),
    .wb_wstrb_i   (wb_wstrb),
    .sb_full_o    (sb_full),
    .sb_empty_o   (sb_empty),
    .sb_count_o   (sb_count),
    .sb_ovf_o     (sb_ovf),
    .ld_busy_i    (ld_busy),
    .ld_check_i   (ld_check),
    .ld_addr_i    (ld_addr),
    .ld_hazard_o  (ld_hazard),
    .dc_req_o     (dc_req),
    .dc_addr_o    (dc_addr),
    .dc_wdata_o   (dc_wdata),
    .dc_wstrb_o   (dc_wstrb),
    .dc_addr_ok_i (dc_addr_ok),
    .dc_data_ok_i (dc_data_ok)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t mq[$];
  int   phase = 0;          // 0 waiting to start, 1 requesting, 2 awaiting completion
  bit   m_ovf = 1'b0;
  bit   m_full, m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      phase = 0;
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_push = wb_we && !m_full;
      m_pop  = (phase == 2) && dc_data_ok;
      if (wb_we && m_full) m_ovf = 1'b1;
      if (phase == 0) begin
        if (mq.size() != 0 && (!ld_busy || m_full)) phase = 1;
      end else if (phase == 1) begin
        if (dc_addr_ok) phase = 2;
      end else begin
        if (dc_data_ok) phase = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{a: wb_addr, d: wb_wdata, s: wb_wstrb});
    end
  end

  // Every-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      ent_t hd;
      bit   hz;
      hd = '0;
      if (phase == 1) hd = mq[0];
      hz = 1'b0;
      foreach (mq[i]) if (mq[i].a[31:2] == ld_addr[31:2]) hz = 1'b1;
      hz = hz && ld_check;
      chk("m_count",  sb_count, mq.size());
      chk("m_full",   sb_full,  mq.size() == DEPTH);
      chk("m_empty",  sb_empty, mq.size() == 0);
      chk("m_ovf",    sb_ovf,   m_ovf);
      chk("m_req",    dc_req,   phase == 1);
      chk("m_addr",   dc_addr,  hd.a);
      chk("m_wdata",  dc_wdata, hd.d);
      chk("m_wstrb",  dc_wstrb, hd.s);
      chk("m_hazard", ld_hazard, hz);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_we = 1'b1; wb_addr = a; wb_wdata = d; wb_wstrb = s;
    step();
    wb_we = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int n = 0;
    while (!dc_req && n < 20) begin
      step();
      n++;
    end
    if (!dc_req) chk("req_timeout", dc_req, 1'b1);
    a = dc_addr;
  endtask

  task automatic drain(input logic [31:0] exp_addr);
    logic [31:0] a;
    wait_req(a);
    chk("drain_order", a, exp_addr);
    dc_addr_ok = 1'b1;
    step();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b1;
    step();
    dc_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    // reset values while held in reset
    ld_check = 1'b1;
    step();
    chk("rst_req",   dc_req, 1'b0);
    chk("rst_empty", sb_empty, 1'b1);
    chk("rst_full",  sb_full, 1'b0);
    chk("rst_count", sb_count, 3'd0);
    chk("rst_ovf",   sb_ovf, 1'b0);
    chk("rst_addr",  dc_addr, 32'h0);
    chk("rst_haz",   ld_hazard, 1'b0);
    ld_check = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // single store, zero-latency dcache
    push(32'h1000, 32'hAABBCCDD, 4'hF);
    chk("t1_count1", sb_count, 3'd1);
    chk("t1_noreq",  dc_req, 1'b0);
    step();
    chk("t1_req",   dc_req, 1'b1);
    chk("t1_addr",  dc_addr, 32'h1000);
    chk("t1_wdata", dc_wdata, 32'hAABBCCDD);
    chk("t1_wstrb", dc_wstrb, 4'hF);
    dc_addr_ok = 1'b1;
    step();
    dc_addr_ok = 1'b0;
    chk("t1_wait_noreq", dc_req, 1'b0);
    dc_data_ok = 1'b1;
    step();
    dc_data_ok = 1'b0;
    chk("t1_count0", sb_count, 3'd0);
    chk("t1_empty",  sb_empty, 1'b1);

    // loads hold off draining until full; overflow is sticky
    ld_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 32'h11110000 + 32'(i), 4'h1 << i);
    chk("t2_count4", sb_count, 3'd4);
    chk("t2_full",   sb_full, 1'b1);
    chk("t2_noreq",  dc_req, 1'b0);
    push(32'h1010, 32'hDEAD0000, 4'hF);
    chk("t2_ovf",     sb_ovf, 1'b1);
    chk("t2_count",   sb_count, 3'd4);
    chk("t2_req",     dc_req, 1'b1);
    chk("t2_head",    dc_addr, 32'h1000);
    drain(32'h1000);
    step();
    step();
    chk("t2_ld_prio", dc_req, 1'b0);
    ld_busy = 1'b0;
    drain(32'h1004);
    drain(32'h1008);
    drain(32'h100C);
    chk("t2_ovf_hold", sb_ovf, 1'b1);

    // in-order drain with pointer wrap
    do_reset();
    chk("t3_ovf_clr", sb_ovf, 1'b0);
    ld_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 32'h22220000 + 32'(i), 4'hF);
    ld_busy = 1'b0;
    for (int i = 0; i < 4; i++) drain(32'h2000 + 32'(4 * i));
    push(32'h3000, 32'h33333333, 4'h3);
    drain(32'h3000);
    chk("t3_empty", sb_empty, 1'b1);

    // word-granular load hazard
    ld_busy = 1'b1;
    push(32'h1004, 32'h44444444, 4'h2);
    ld_check = 1'b1;
    ld_addr = 32'h1006; #1;
    chk("t4_haz_1006", ld_hazard, 1'b1);
    ld_addr = 32'h1007; #1;
    chk("t4_haz_1007", ld_hazard, 1'b1);
    ld_addr = 32'h1008; #1;
    chk("t4_haz_1008", ld_hazard, 1'b0);
    ld_addr = 32'h1003; #1;
    chk("t4_haz_1003", ld_hazard, 1'b0);
    ld_check = 1'b0; ld_addr = 32'h1006; #1;
    chk("t4_haz_nochk", ld_hazard, 1'b0);
    ld_check = 1'b1;
    ld_busy = 1'b0;
    drain(32'h1004);
    chk("t4_haz_gone", ld_hazard, 1'b0);
    ld_check = 1'b0;

    // push and pop in the same cycle at count 2
    ld_busy = 1'b1;
    push(32'h4000, 32'h40404040, 4'hF);
    push(32'h4004, 32'h40404044, 4'hF);
    ld_busy = 1'b0;
    wait_req(a);
    chk("t5_head0", a, 32'h4000);
    dc_addr_ok = 1'b1;
    step();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b1;
    wb_we = 1'b1; wb_addr = 32'h4008; wb_wdata = 32'h40404048; wb_wstrb = 4'hC;
    step();
    dc_data_ok = 1'b0;
    wb_we = 1'b0;
    chk("t5_count2", sb_count, 3'd2);
    drain(32'h4004);
    drain(32'h4008);

    // asynchronous reset while awaiting completion with 3 entries
    ld_busy = 1'b1;
    push(32'h5000, 32'h5, 4'hF);
    push(32'h5004, 32'h6, 4'hF);
    push(32'h5008, 32'h7, 4'hF);
    ld_busy = 1'b0;
    wait_req(a);
    dc_addr_ok = 1'b1;
    step();
    dc_addr_ok = 1'b0;
    chk("t6_count3", sb_count, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req",   dc_req, 1'b0);
    chk("t6_count", sb_count, 3'd0);
    chk("t6_empty", sb_empty, 1'b1);
    step();
    rst_n = 1'b1;
    dc_data_ok = 1'b1;
    step();
    dc_data_ok = 1'b0;
    chk("t6_late_count", sb_count, 3'd0);
    chk("t6_late_req",   dc_req, 1'b0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
